// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter among NUM_REQ sources,
// with packet lock (grant held until a byte flagged last) and optional HOLD timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int IDX_W        = 2,
   parameter int HOLD_TIMEOUT = 0,
   parameter int TO_W         = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   input  logic [NUM_REQ-1:0]     i_req_last,
   output logic [NUM_REQ-1:0]     o_req_ready,
   output logic                   o_tx_data_avail,
   output logic [7:0]             o_tx_data_byte,
   input  logic                   i_tx_active,
   input  logic                   i_tx_done,
   output logic [IDX_W-1:0]       o_grant_idx,
   output logic                   o_busy,
   output logic                   o_abort
);

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      HOLD      = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic [7:0]           byte_q, byte_d;
   logic                 lock_q, lock_d;
   logic                 avail_q, avail_d;
   logic                 abort_q, abort_d;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic [1:0]           rst_sync_q;
   logic                 rst_int_s;
   logic                 win_found_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic                 take_s;
   logic [IDX_W-1:0]     sel_s;
   logic [NUM_REQ-1:0]   req_ready_s;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(NUM_REQ - 1)) begin
         return '0;
      end else begin
         return idx + IDX_W'(1);
      end
   endfunction

   // Reset synchroniser: assertion is immediate, release follows two clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync_q <= 2'b11;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b0};
      end
   end

   assign rst_int_s = rst_sync_q[1];

   // Round-robin scan starting at the priority pointer.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = rr_ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found_s && i_req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
            win_found_s = 1'b1;
            win_idx_s   = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state, accept strobe and captured-byte selection.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      byte_d      = byte_q;
      lock_d      = lock_q;
      to_cnt_d    = to_cnt_q;
      avail_d     = 1'b0;
      abort_d     = 1'b0;
      take_s      = 1'b0;
      sel_s       = grant_q;
      req_ready_s = '0;
      case (state_q)
         ARB: begin
            // A frame may still be running from before our reset; never overlap it.
            if (!i_tx_active && win_found_s) begin
               take_s = 1'b1;
               sel_s  = win_idx_s;
            end else begin
               take_s = 1'b0;
            end
         end
         ISSUE: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               if (lock_q) begin
                  state_d  = HOLD;
                  to_cnt_d = '0;
               end else begin
                  rr_ptr_d = wrap_inc(grant_q);
                  state_d  = ARB;
               end
            end else begin
               state_d = WAIT_DONE;
            end
         end
         HOLD: begin
            if (i_req_valid[grant_q]) begin
               to_cnt_d = '0;
               if (!i_tx_active) begin
                  take_s = 1'b1;
               end else begin
                  take_s = 1'b0;
               end
            end else if ((HOLD_TIMEOUT > 0) && (to_cnt_q == TO_W'(HOLD_TIMEOUT - 1))) begin
               abort_d  = 1'b1;
               lock_d   = 1'b0;
               rr_ptr_d = wrap_inc(grant_q);
               state_d  = ARB;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
      if (take_s) begin
         req_ready_s[sel_s] = 1'b1;
         byte_d             = i_req_data[8*int'(sel_s) +: 8];
         lock_d             = ~i_req_last[sel_s];
         grant_d            = sel_s;
         avail_d            = 1'b1;
         state_d            = ISSUE;
      end else begin
         avail_d = 1'b0;
      end
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or posedge rst_int_s) begin
      if (rst_int_s) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         byte_q   <= 8'h00;
         lock_q   <= 1'b0;
         avail_q  <= 1'b0;
         abort_q  <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         byte_q   <= byte_d;
         lock_q   <= lock_d;
         avail_q  <= avail_d;
         abort_q  <= abort_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   assign o_req_ready     = req_ready_s & {NUM_REQ{~rst_int_s}};
   assign o_tx_data_avail = avail_q;
   assign o_tx_data_byte  = byte_q;
   assign o_grant_idx     = grant_q;
   assign o_busy          = (state_q != ARB);
   assign o_abort         = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter, packet-queue reference model of the
// round-robin/packet-lock order, plus directed latency, timeout and reset-mid-frame cases.
module tb_uart_tx_arbiter;

   localparam int NR    = 4;
   localparam int IW    = 2;
   localparam int HT    = 8;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [8*NR-1:0]   req_data = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR-1:0]     req_ready;
   logic              tx_avail;
   logic [7:0]        tx_byte;
   logic              tx_active = 1'b0;
   logic              tx_done_m = 1'b0;
   logic              done_inj = 1'b0;
   logic              tx_done;
   logic [IW-1:0]     grant_idx;
   logic              busy;
   logic              abort_p;

   int                tx_cnt = 0;
   logic [9:0]        tx_frame = 10'h3FF;
   logic              tx_serial;
   logic [9:0]        rx_sh = 10'h000;
   int                viol = 0;

   int                n_checks = 0;
   int                n_err = 0;

   logic [7:0]        pd [NR][8];
   logic              pl [NR][8];
   int                plen [NR];
   int                hd [NR];
   int                model_ptr = 0;

   always #5 clk = ~clk;

   assign tx_done = tx_done_m | done_inj;

   uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .HOLD_TIMEOUT(HT), .TO_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req_valid     (req_valid),
      .i_req_data      (req_data),
      .i_req_last      (req_last),
      .o_req_ready     (req_ready),
      .o_tx_data_avail (tx_avail),
      .o_tx_data_byte  (tx_byte),
      .i_tx_active     (tx_active),
      .i_tx_done       (tx_done),
      .o_grant_idx     (grant_idx),
      .o_busy          (busy),
      .o_abort         (abort_p)
   );

   // Transmitter model: start, 8 data LSB first, stop; unaffected by the arbiter's reset.
   always @(posedge clk) begin
      tx_done_m <= 1'b0;
      if (tx_cnt > 0) begin
         tx_cnt <= tx_cnt - 1;
         if (tx_cnt == 1) begin
            tx_active <= 1'b0;
            tx_done_m <= 1'b1;
         end
      end else if (tx_avail) begin
         tx_cnt    <= FRAME;
         tx_active <= 1'b1;
         tx_frame  <= {1'b1, tx_byte, 1'b0};
      end
   end

   assign tx_serial = tx_active ? tx_frame[(FRAME - tx_cnt) / CPB] : 1'b1;

   // Mid-bit line receiver and protocol monitors.
   always @(negedge clk) begin
      if (tx_active && (((FRAME - tx_cnt) % CPB) == 2)) rx_sh <= {tx_serial, rx_sh[9:1]};
      if (!$onehot0(req_ready)) viol <= viol + 1;
      if (tx_avail && tx_active) viol <= viol + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_pk();
      for (int k = 0; k < NR; k++) plen[k] = 0;
   endtask

   task automatic add_byte(input int k, input logic [7:0] b, input logic last);
      pd[k][plen[k]] = b;
      pl[k][plen[k]] = last;
      plen[k]++;
   endtask

   task automatic drive_heads();
      for (int k = 0; k < NR; k++) begin
         if (hd[k] < plen[k]) begin
            req_valid[k]        = 1'b1;
            req_data[8*k +: 8]  = pd[k][hd[k]];
            req_last[k]         = pl[k][hd[k]];
         end else begin
            req_valid[k]        = 1'b0;
            req_data[8*k +: 8]  = 8'h00;
            req_last[k]         = 1'b0;
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      model_ptr = 0;
   endtask

   // Reference: whole packets in rotation from the pointer; pointer moves past each finished packet.
   task automatic run_sched(input string tag);
      int  er[$];
      int  eb[$];
      int  mh[NR];
      int  k;
      int  nfr;
      int  last_done;
      bit  found;
      bit  idle_ok;
      bit  pop[NR];
      for (int i = 0; i < NR; i++) mh[i] = 0;
      for (int it = 0; it < 64; it++) begin
         found = 1'b0;
         for (int i = 0; i < NR; i++) begin
            k = (model_ptr + i) % NR;
            if (!found && mh[k] < plen[k]) begin
               found = 1'b1;
               do begin
                  er.push_back(k);
                  eb.push_back(int'(pd[k][mh[k]]));
                  mh[k]++;
               end while (!pl[k][mh[k]-1] && mh[k] < plen[k]);
               model_ptr = (k + 1) % NR;
            end
         end
         if (!found) break;
      end
      for (int i = 0; i < NR; i++) hd[i] = 0;
      drive_heads();
      nfr = 0;
      last_done = -100;
      for (int c = 0; c < 3000 && nfr < er.size(); c++) begin
         @(negedge clk);
         if (tx_done) last_done = c;
         if (tx_avail) begin
            check_eq({tag, "_grant"}, 32'(grant_idx), er[nfr]);
            check_eq({tag, "_byte"}, 32'(tx_byte), eb[nfr]);
            if (nfr > 0) check_eq({tag, "_gap"}, c - last_done, 32'd2);
            nfr++;
         end
         for (int i = 0; i < NR; i++) pop[i] = req_valid[i] & req_ready[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) if (pop[i]) hd[i]++;
         drive_heads();
      end
      check_eq({tag, "_frames"}, nfr, er.size());
      for (int i = 0; i < NR; i++) check_eq({tag, "_drained"}, hd[i], plen[i]);
      idle_ok = 1'b0;
      for (int w = 0; w < FRAME + 20; w++) begin
         @(negedge clk);
         if (tx_done) begin
            idle_ok = 1'b1;
            break;
         end
      end
      check_eq({tag, "_idle"}, 32'(idle_ok), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < FRAME + 20; w++) begin
         @(negedge clk);
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_ready(input string tag, input int k);
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (req_ready[k]) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int n;
      int rdy_in_hold;
      int blk;
      int np;
      int len;
      bit ab_seen;

      // Reset values, with all requesters valid to show ready is held low.
      req_valid = '1;
      req_data  = 32'hDEADBEEF;
      @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_avail", 32'(tx_avail), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_grant", 32'(grant_idx), 32'd0);
      check_eq("rst_byte", 32'(tx_byte), 32'd0);
      check_eq("rst_abort", 32'(abort_p), 32'd0);
      apply_reset();

      // Test 1: single byte, latency and serial frame.
      req_valid = 4'b0001;
      req_data  = 32'h000000A5;
      req_last  = 4'b0001;
      @(negedge clk);
      check_eq("t1_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      check_eq("t1_avail", 32'(tx_avail), 32'd1);
      check_eq("t1_byte", 32'(tx_byte), 32'hA5);
      check_eq("t1_grant", 32'(grant_idx), 32'd0);
      check_eq("t1_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_eq("t1_avail_width", 32'(tx_avail), 32'd0);
      wait_done("t1_done");
      check_eq("t1_serial", 32'(rx_sh), 32'(10'b1101001010));
      @(negedge clk);
      check_eq("t1_busy_after", 32'(busy), 32'd0);

      // Test 2: all four valid, single-byte packets; strict rotation from reset.
      apply_reset();
      clear_pk();
      add_byte(0, 8'h11, 1'b1);
      add_byte(0, 8'h55, 1'b1);
      add_byte(1, 8'h22, 1'b1);
      add_byte(2, 8'h33, 1'b1);
      add_byte(3, 8'h44, 1'b1);
      run_sched("t2");

      // Test 3: 3-byte packet from req1 stays contiguous.
      clear_pk();
      add_byte(0, 8'hA0, 1'b1);
      add_byte(1, 8'hB1, 1'b0);
      add_byte(1, 8'hB2, 1'b0);
      add_byte(1, 8'hB3, 1'b1);
      add_byte(2, 8'hC0, 1'b1);
      run_sched("t3");

      // Test 4: req3 opens a packet and goes quiet; HOLD times out.
      @(posedge clk);
      #1;
      req_valid = 4'b1000;
      req_data  = 32'h3C000000;
      req_last  = 4'b0000;
      wait_ready("t4_ready3", 3);
      @(posedge clk);
      #1;
      req_valid = 4'b0101;
      req_data  = 32'h002A000A;
      req_last  = 4'b0101;
      wait_done("t4_done");
      n = 0;
      rdy_in_hold = 0;
      ab_seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         n++;
         done_inj = (n == 3);
         if (abort_p) begin
            ab_seen = 1'b1;
            break;
         end
         if (req_ready != '0) rdy_in_hold++;
      end
      done_inj = 1'b0;
      check_eq("t4_abort_seen", 32'(ab_seen), 32'd1);
      check_eq("t4_abort_delay", n, 32'd9);
      check_eq("t4_ready_in_hold", rdy_in_hold, 32'd0);
      check_eq("t4_busy_at_abort", 32'(busy), 32'd0);
      check_eq("t4_next_ready", 32'(req_ready), 32'd1);
      req_valid = '0;
      @(negedge clk);
      check_eq("t4_abort_width", 32'(abort_p), 32'd0);
      check_eq("t4_drop_no_avail", 32'(tx_avail), 32'd0);
      @(posedge clk);
      #1;
      model_ptr = 0;
      clear_pk();
      add_byte(0, 8'h0A, 1'b1);
      add_byte(2, 8'h2A, 1'b1);
      run_sched("t4");

      // Test 5: reset mid-frame while the transmitter keeps running.
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      req_data  = 32'h00005E00;
      req_last  = 4'b0010;
      wait_ready("t5_ready1", 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (12) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t5_tx_active", 32'(tx_active), 32'd1);
      check_eq("t5_ready", 32'(req_ready), 32'd0);
      check_eq("t5_busy", 32'(busy), 32'd0);
      check_eq("t5_grant", 32'(grant_idx), 32'd0);
      check_eq("t5_byte", 32'(tx_byte), 32'd0);
      check_eq("t5_avail", 32'(tx_avail), 32'd0);
      req_valid = 4'b0100;
      req_data  = 32'h00770000;
      req_last  = 4'b0100;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      blk = 0;
      for (int w = 0; w < FRAME + 10; w++) begin
         @(negedge clk);
         if (!tx_active) break;
         if (req_ready != '0 || tx_avail) blk++;
      end
      check_eq("t5_blocked", blk, 32'd0);
      check_eq("t5_stale_done", 32'(tx_done), 32'd1);
      check_eq("t5_stale_busy", 32'(busy), 32'd0);
      check_eq("t5_ready2", 32'(req_ready), 32'd4);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      check_eq("t5_avail2", 32'(tx_avail), 32'd1);
      check_eq("t5_byte2", 32'(tx_byte), 32'h77);
      check_eq("t5_grant2", 32'(grant_idx), 32'd2);
      wait_done("t5_done2");
      model_ptr = 3;

      // Test 6: stray done pulse in ARB.
      @(negedge clk);
      done_inj = 1'b1;
      @(negedge clk);
      done_inj = 1'b0;
      check_eq("t6_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("t6_busy2", 32'(busy), 32'd0);
      check_eq("t6_avail", 32'(tx_avail), 32'd0);
      @(posedge clk);
      #1;

      // Randomised packet sets against the reference order.
      for (int r = 0; r < 3; r++) begin
         clear_pk();
         for (int k = 0; k < NR; k++) begin
            np = $urandom_range(0, 2);
            if (k == 0 && np == 0) np = 1;
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), (b == len - 1));
            end
         end
         run_sched("rnd");
      end

      check_eq("monitor_viol", viol, 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
